sseg_scan_driver: RTL
=====================

// Module: sseg_scan_driver
// PURPOSE
//  Multiplexed seven-segment display driver for the Elbert V2 3-digit display. It consumes
//  per-digit hex values and turns them into time-sliced sseg/sseg_en pin drive.
//  Sits between result-producing logic (e.g. comparator status digits) and the board pins.
//  Inputs are captured once per frame so a displayed frame never mixes old and new values.
// PARAMETERS
//  NUM_DIGITS    3      digits scanned, slot index 0..NUM_DIGITS-1, digit 0 = rightmost
//  SCAN_DIV      12000  clk cycles per digit slot (1 kHz/slot at 12 MHz)
//  BLANK_CYCLES  120    dead-time cycles at slot start, all digits off; must be < SCAN_DIV
// PORTS
//  clk          in   1             system clock, all logic on rising edge
//  rst_n        in   1             asynchronous, active-low reset
//  enable       in   1             1 = display on; 0 = force blank, scan counters keep running
//  digit_val    in   4*NUM_DIGITS  hex value per digit, digit i = [4i+3:4i]
//  digit_dp     in   NUM_DIGITS    decimal point per digit, 1 = lit
//  digit_blank  in   NUM_DIGITS    1 = digit i fully dark for its slot
//  sseg         out  8             segments {dp,g,f,e,d,c,b,a}, active-low
//  sseg_en      out  NUM_DIGITS    digit enables, active-low, at most one low at any time
//  frame_tick   out  1             one-cycle pulse at start of each frame (slot 0, cycle 0)
// BEHAVIOUR
//  - Reset (async assert, sync release): sseg=8'hFF, sseg_en=all 1, frame_tick=0,
//    slot index=0, cycle count=0, shadow registers cleared.
//  - Cycle counter cnt runs 0..SCAN_DIV-1, then wraps to 0 and advances slot idx;
//    idx wraps NUM_DIGITS-1 -> 0. The first edge after rst_n release is cnt=0, idx=0.
//  - Frame capture: on every edge where cnt=0 and idx=0, digit_val/dp/blank are loaded into
//    shadow registers. All display output comes only from the shadows.
//  - All outputs are registered. State (idx,cnt) appears on the pins one cycle later.
//  - Blank phase, cnt < BLANK_CYCLES: sseg=8'hFF, sseg_en=all 1.
//  - Drive phase, cnt >= BLANK_CYCLES: the following apply.
//    - sseg_en[idx]=0 and all other enables are 1.
//    - sseg[6:0] = hex decode of shadow value idx.
//    - sseg[7] = ~shadow_dp[idx].
//    - Exception: if enable=0 or shadow_blank[idx]=1, then sseg=8'hFF and sseg_en=all 1.
//  - enable is sampled every cycle, not per frame. Its effect shows on the pins one cycle later.
//  - frame_tick=1 for exactly the one cycle whose pins reflect idx=0, cnt=0.
//    Period is NUM_DIGITS*SCAN_DIV.
//  - Hex decode, active-low g..a: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
//    A=08 b=03 C=46 d=21 E=06 F=0E.
//  - Input changes mid-frame are invisible until the next frame capture.
//  - Reset mid-slot: pins blank immediately (async), and scan restarts at idx 0.
// STRUCTURE
//  - Package sseg_pkg holds: the 16-entry active-low hex segment constant table,
//    SSEG_OFF=8'hFF, and the segment bit-position localparams.
//  - Sub-module hex_to_sseg: combinational, 4-bit value -> 7-bit active-low pattern,
//    reusable by other display blocks.
//  - Top level holds cnt ($clog2(SCAN_DIV) bits), idx, shadow registers and output registers.
// TESTING (bench params NUM_DIGITS=3, SCAN_DIV=8, BLANK_CYCLES=2)
//  1. Hold rst_n=0, then release.
//     -> During reset: sseg=FF, sseg_en=111.
//     -> After release: first frame_tick 1 cycle later, then frame_tick every 24 cycles.
//  2. digit_val=12'h3A7, dp=000, blank=000, enable=1.
//     -> Slot 0: 2 cycles of 111/FF, then 6 cycles of sseg_en=110, sseg=8'hF8.
//     -> Slot 1: sseg_en=101, sseg=8'h88.
//     -> Slot 2: sseg_en=011, sseg=8'hB0.
//  3. Change digit_val to 12'h000 during slot 1 of a frame.
//     -> Slots 1 and 2 still show A and 3.
//     -> The next frame shows sseg=8'hC0 on all digits.
//  4. digit_blank=010, digit_dp=001.
//     -> Slot 1 stays 111/FF for all 8 cycles.
//     -> Slot 0 has sseg[7]=0.
//     -> At most one sseg_en bit is low on every cycle.
//  5. Drop enable to 0 mid drive phase.
//     -> One cycle later: sseg=FF, sseg_en=111.
//     -> frame_tick spacing is unchanged.
//     -> Re-enabling resumes on the correct digit.
//  6. Assert rst_n=0 mid slot 2 for 3 cycles.
//     -> Pins go blank asynchronously.
//     -> After release, scan restarts at slot 0 and frame_tick occurs.

Source files
------------

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared seven-segment constants (active-low hex patterns, segment bit positions)
package sseg_pkg;
  localparam logic [7:0] SSEG_OFF = 8'hFF;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_DP = 7;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/hex_to_sseg.sv
// hex_to_sseg: 4-bit value to active-low {g..a} segment pattern
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[val];
endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexed seven-segment scan with per-frame input capture and dead time
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV = 12000,
  parameter int BLANK_CYCLES = 120
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digit_val,
  input  logic [NUM_DIGITS-1:0]   digit_dp,
  input  logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [7:0]              sseg,
  output logic [NUM_DIGITS-1:0]   sseg_en,
  output logic                    frame_tick
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0] sh_dp, sh_blank;
  logic cap, slot_end, lit, cur_dp, cur_blank;
  logic [3:0] cur_val;
  logic [6:0] hex;
  assign cap = cnt == '0 && idx == '0;
  assign slot_end = cnt == CW'(SCAN_DIV - 1);
  // the capture cycle reads the inputs directly so it already shows the new frame
  always_comb begin
    cur_val = cap ? digit_val[3:0] : sh_val[idx*4 +: 4];
    cur_dp = cap ? digit_dp[0] : sh_dp[idx];
    cur_blank = cap ? digit_blank[0] : sh_blank[idx];
    lit = cnt >= CW'(BLANK_CYCLES) && enable && !cur_blank;
  end
  hex_to_sseg u_hex (.val(cur_val), .seg(hex));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      sh_val <= '0;
      sh_dp <= '0;
      sh_blank <= '0;
      sseg <= SSEG_OFF;
      sseg_en <= '1;
      frame_tick <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + IW'(1);
      if (cap) begin
        sh_val <= digit_val;
        sh_dp <= digit_dp;
        sh_blank <= digit_blank;
      end
      sseg <= lit ? {~cur_dp, hex} : SSEG_OFF;
      sseg_en <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      frame_tick <= cap;
    end
  end
endmodule
